// File: rtl/histo_display_mc_pkg.sv
// Shared definitions for the histogram bar renderer.
//   X_W / Y_W     : raster counter widths (X_Cont / Y_Cont)
//   GRID_PIX      : graticule lane intensity (only with HISTO_DISP_GRID_EN)
//   stage_ctl_t   : per-pixel control flags carried down the pipeline
//   prod_w()      : width of the unsigned count*V_RES / row*max products
// Optional feature macro: HISTO_DISP_GRID_EN (grey graticule rows).
package histo_display_mc_pkg;

  localparam int X_W = 11;
  localparam int Y_W = 10;

`ifdef HISTO_DISP_GRID_EN
  localparam logic [7:0] GRID_PIX = 8'h40;
`endif

  typedef struct packed {
    logic valid;
    logic in_plot;
    logic red;
  } stage_ctl_t;

  // Both products fit in count width plus row width, so nothing is truncated.
  function automatic int prod_w(input int cnt_w, input int v_res);
    return cnt_w + $clog2(v_res);
  endfunction

endpackage

// File: rtl/histo_display_mc_bar_cmp.sv
// Per-channel bar compare: registers the RAM count, holds the frame-latched
// maximum and decides whether the pixel at `row` (0 = bottom) is under the bar.
//   clk_sys, rst_b : clock, async active-low reset
//   load_s0        : frame start seen at the pipeline input; sample max_in
//   load_s1        : same event one stage later; commit the sampled maximum
//   max_in         : full-scale count for this channel
//   count_in       : histogram RAM read data for the current pixel
//   qual           : pixel is valid and inside the plot area
//   row            : bar row of the pixel in the count stage
//   lit            : registered lit flag, aligned with oValid
module histo_display_mc_bar_cmp
  import histo_display_mc_pkg::*;
#(
  parameter int CNT_W = 20,
  parameter int V_RES = 480
) (
  input  logic                     clk_sys,
  input  logic                     rst_b,
  input  logic                     load_s0,
  input  logic                     load_s1,
  input  logic [CNT_W-1:0]         max_in,
  input  logic [CNT_W-1:0]         count_in,
  input  logic                     qual,
  input  logic [$clog2(V_RES)-1:0] row,
  output logic                     lit
);

  localparam int PW = prod_w(CNT_W, V_RES);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] max_pend;
  logic [CNT_W-1:0] max_q;
  logic [PW-1:0]    bar_prod;
  logic [PW-1:0]    row_prod;
  logic             lit_d;

  // The committed maximum switches one stage late so the pixel sitting in
  // the compare stage when a new frame enters still uses the old frame's scale.
  always_ff @(posedge clk_sys or negedge rst_b) begin
    if (!rst_b) begin
      count_q  <= '0;
      max_pend <= '0;
      max_q    <= '0;
      lit      <= 1'b0;
    end else begin
      count_q <= count_in;
      if (load_s0) max_pend <= max_in;
      if (load_s1) max_q <= max_pend;
      lit <= lit_d;
    end
  end

  // Lit when count/max > row/V_RES, cross-multiplied; count >= max fills the column.
  assign bar_prod = PW'(count_q) * PW'(V_RES);
  assign row_prod = PW'(row) * PW'(max_q);
  assign lit_d    = qual && (max_q != '0) && (bar_prod > row_prod);

endmodule

// File: rtl/histo_display_mc.sv
// Multi-channel histogram bar renderer for the LCD path. Walks the raster,
// addresses the shared histogram RAMs and emits one lane per channel plus a
// red threshold-marker lane, with a fixed 3-cycle latency.
//   iClk, iRst_n         : clock, async active-low reset
//   iValid, X_Cont/Y_Cont: raster position, Y=0 is the top row
//   iHistoValue          : RAM read data (1-cycle read of oHistoAddr)
//   iMaxValue            : per-channel full scale, latched at X=0,Y=0
//   iThreshPoint         : bin drawn as the red marker column
//   oHistoAddr           : shared RAM read address
//   oPixel / oRed        : per-channel lanes / marker lane
//   oValid               : output pixel valid
// Optional feature macro: HISTO_DISP_GRID_EN (grey graticule on quarter rows).
module histo_display_mc
  import histo_display_mc_pkg::*;
#(
  parameter int H_RES  = 800,
  parameter int V_RES  = 480,
  parameter int BINS   = 256,
  parameter int BIN_PX = 3,
  parameter int CNT_W  = 20,
  parameter int NUM_CH = 3,
  parameter int PIX_W  = 8
) (
  input  logic                    iClk,
  input  logic                    iRst_n,
  input  logic                    iValid,
  input  logic [X_W-1:0]          X_Cont,
  input  logic [Y_W-1:0]          Y_Cont,
  input  logic [NUM_CH*CNT_W-1:0] iHistoValue,
  input  logic [NUM_CH*CNT_W-1:0] iMaxValue,
  input  logic [$clog2(BINS)-1:0] iThreshPoint,
  output logic [$clog2(BINS)-1:0] oHistoAddr,
  output logic [NUM_CH*PIX_W-1:0] oPixel,
  output logic [PIX_W-1:0]        oRed,
  output logic                    oValid
);

  localparam int AW     = $clog2(BINS);
  localparam int RW     = $clog2(V_RES);
  localparam int SW     = (BIN_PX > 1) ? $clog2(BIN_PX) : 1;
  localparam int PLOT_W = (BINS * BIN_PX < H_RES) ? BINS * BIN_PX : H_RES;

  localparam logic [X_W-1:0] PLOT_END = X_W'(PLOT_W);
  localparam logic [Y_W-1:0] ROW_END  = Y_W'(V_RES);
  localparam logic [Y_W-1:0] ROW_TOP  = Y_W'(V_RES - 1);
  localparam logic [SW-1:0]  SUB_LAST = SW'(BIN_PX - 1);

  // Bin tracking state, updated on valid pixels only.
  logic [X_W-1:0] x_q;
  logic [AW-1:0]  bin_q, prev_bin, cur_bin;
  logic [SW-1:0]  sub_q, prev_sub, cur_sub;
  logic           resync_q;
  logic           nonseq;

  // Pipeline
  logic           in_plot_d;
  logic [RW-1:0]  row_d;
  logic           max_load_d;
  stage_ctl_t     ctl0, ctl1;
  logic [RW-1:0]  row0, row1;
  logic           load0;
  logic [NUM_CH-1:0] lit;

  // After a jump in X the counter is rebuilt from the previous X with a
  // constant divide, off the input-to-register path.
  always_comb begin
    prev_bin = bin_q;
    prev_sub = sub_q;
    if (resync_q) begin
      prev_bin = AW'(x_q / X_W'(BIN_PX));
      prev_sub = SW'(x_q % X_W'(BIN_PX));
    end
  end

  always_comb begin
    cur_bin = prev_bin;
    cur_sub = prev_sub;
    nonseq  = 1'b0;
    if (X_Cont == '0) begin
      cur_bin = '0;
      cur_sub = '0;
    end else if (X_Cont == x_q + X_W'(1)) begin
      if (prev_sub == SUB_LAST) begin
        cur_bin = prev_bin + AW'(1);
        cur_sub = '0;
      end else begin
        cur_sub = prev_sub + SW'(1);
      end
    end else begin
      nonseq = 1'b1;
    end
  end

  // A jumped pixel has no trustworthy bin yet, so it is drawn as background.
  assign in_plot_d  = iValid && !nonseq && (X_Cont < PLOT_END) && (Y_Cont < ROW_END);
  assign row_d      = (Y_Cont < ROW_END) ? RW'(ROW_TOP - Y_Cont) : '0;
  assign max_load_d = iValid && (X_Cont == '0) && (Y_Cont == '0);

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      x_q      <= '0;
      bin_q    <= '0;
      sub_q    <= '0;
      resync_q <= 1'b0;
    end else if (iValid) begin
      x_q      <= X_Cont;
      bin_q    <= cur_bin;
      sub_q    <= cur_sub;
      resync_q <= nonseq;
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      oHistoAddr <= '0;
      ctl0       <= '0;
      ctl1       <= '0;
      row0       <= '0;
      row1       <= '0;
      load0      <= 1'b0;
      oValid     <= 1'b0;
      oRed       <= '0;
    end else begin
      oHistoAddr    <= cur_bin;
      ctl0.valid    <= iValid;
      ctl0.in_plot  <= in_plot_d;
      ctl0.red      <= in_plot_d && (cur_bin == iThreshPoint);
      row0          <= row_d;
      load0         <= max_load_d;
      ctl1          <= ctl0;
      row1          <= row0;
      oValid        <= ctl1.valid;
      oRed          <= {PIX_W{ctl1.red}};
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    histo_display_mc_bar_cmp #(
      .CNT_W (CNT_W),
      .V_RES (V_RES)
    ) u_bar (
      .clk_sys  (iClk),
      .rst_b    (iRst_n),
      .load_s0  (max_load_d),
      .load_s1  (load0),
      .max_in   (iMaxValue[c*CNT_W +: CNT_W]),
      .count_in (iHistoValue[c*CNT_W +: CNT_W]),
      .qual     (ctl1.in_plot),
      .row      (row1),
      .lit      (lit[c])
    );
  end

`ifdef HISTO_DISP_GRID_EN
  localparam logic [RW-1:0] GRID_STEP = RW'(V_RES / 4);

  logic grid_q;

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) grid_q <= 1'b0;
    else         grid_q <= ctl1.in_plot && ((row1 % GRID_STEP) == '0);
  end

  always_comb begin
    oPixel = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (lit[c])
        oPixel[c*PIX_W +: PIX_W] = '1;
      else if (grid_q && (lit == '0))
        oPixel[c*PIX_W +: PIX_W] = PIX_W'(GRID_PIX);
    end
  end
`else
  always_comb begin
    oPixel = '0;
    for (int c = 0; c < NUM_CH; c++)
      oPixel[c*PIX_W +: PIX_W] = {PIX_W{lit[c]}};
  end
`endif

endmodule

// File: tb/tb_histo_display_mc.sv
module tb_histo_display_mc;

  localparam int H      = 30;
  localparam int V      = 16;
  localparam int BINS   = 8;
  localparam int BIN_PX = 3;
  localparam int CNT_W  = 20;
  localparam int NUM_CH = 3;
  localparam int PIX_W  = 8;
  localparam int AW     = 3;
  localparam int PLOT   = BINS * BIN_PX;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    vld = 1'b0;
  logic [10:0]             xc = '0;
  logic [9:0]              yc = '0;
  logic [NUM_CH*CNT_W-1:0] hv;
  logic [NUM_CH*CNT_W-1:0] mx = '0;
  logic [AW-1:0]           thr = '0;
  logic [AW-1:0]           addr;
  logic [NUM_CH*PIX_W-1:0] pix;
  logic [PIX_W-1:0]        red;
  logic                    ov;

  logic [CNT_W-1:0] mem [NUM_CH][BINS];

  always #5 clk = ~clk;

  // Histogram RAMs: data for the registered address arrives in the next stage.
  always_comb begin
    hv = '0;
    for (int c = 0; c < NUM_CH; c++) hv[c*CNT_W +: CNT_W] = mem[c][addr];
  end

  histo_display_mc #(
    .H_RES (H), .V_RES (V), .BINS (BINS), .BIN_PX (BIN_PX),
    .CNT_W (CNT_W), .NUM_CH (NUM_CH), .PIX_W (PIX_W)
  ) dut (
    .iClk         (clk),
    .iRst_n       (rst_n),
    .iValid       (vld),
    .X_Cont       (xc),
    .Y_Cont       (yc),
    .iHistoValue  (hv),
    .iMaxValue    (mx),
    .iThreshPoint (thr),
    .oHistoAddr   (addr),
    .oPixel       (pix),
    .oRed         (red),
    .oValid       (ov)
  );

  typedef struct {
    logic                    v;
    logic [NUM_CH*PIX_W-1:0] pix;
    logic [PIX_W-1:0]        red;
    int                      x;
    int                      y;
  } exp_t;

  exp_t   exp_q[$];
  int     total = 0;
  int     bad = 0;
  int     prev_x = 0;
  longint mmax[NUM_CH];
  int     lit_by_x[NUM_CH][H];
  int     red_by_x[H];
  int     grid_by_y[V];
  int     bg_hits;

  task automatic clear_tally();
    foreach (lit_by_x[c, i]) lit_by_x[c][i] = 0;
    foreach (red_by_x[i]) red_by_x[i] = 0;
    foreach (grid_by_y[i]) grid_by_y[i] = 0;
    bg_hits = 0;
  endtask

  task automatic model_reset();
    exp_t z;
    exp_q.delete();
    prev_x = 0;
    foreach (mmax[c]) mmax[c] = 0;
    z.v = 1'b0; z.pix = '0; z.red = '0; z.x = 0; z.y = V;
    repeat (3) exp_q.push_back(z);
  endtask

  // One raster cycle: score the pixel that entered three cycles ago, then
  // apply the new inputs and predict their output from the bar rules.
  task automatic drive(input logic v, input int x, input int y);
    exp_t   e;
    bit     nonseq, in_plot, any;
    int     row;
    longint cnt;
    @(negedge clk);
    if (exp_q.size() >= 3) begin
      e = exp_q.pop_front();
      total += 3;
      if (ov !== e.v) begin
        bad++;
        $display("FAIL valid x=%0d y=%0d got=%0b want=%0b", e.x, e.y, ov, e.v);
      end
      if (pix !== e.pix) begin
        bad++;
        $display("FAIL pixel x=%0d y=%0d got=%h want=%h", e.x, e.y, pix, e.pix);
      end
      if (red !== e.red) begin
        bad++;
        $display("FAIL red x=%0d y=%0d got=%h want=%h", e.x, e.y, red, e.red);
      end
      if (ov === 1'b1 && e.x >= 0 && e.x < H && e.y >= 0) begin
        for (int c = 0; c < NUM_CH; c++)
          if (pix[c*PIX_W +: PIX_W] === 8'hFF) lit_by_x[c][e.x]++;
        if (red === 8'hFF) red_by_x[e.x]++;
        if (e.y < V && pix === {NUM_CH{8'h40}}) grid_by_y[e.y]++;
        if ((e.x >= PLOT || e.y >= V) && (pix !== '0 || red !== '0)) bg_hits++;
      end
    end
    vld = v;
    xc  = 11'(x);
    yc  = 10'(y);

    nonseq = v && (x != 0) && (x != prev_x + 1);
    if (v && x == 0 && y == 0)
      for (int c = 0; c < NUM_CH; c++) mmax[c] = longint'(mx[c*CNT_W +: CNT_W]);
    if (v) prev_x = x;
    in_plot = v && !nonseq && (x < PLOT) && (y < V);
    e.v = v; e.pix = '0; e.red = '0; e.x = x; e.y = y;
    if (in_plot) begin
      row = V - 1 - y;
      any = 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        cnt = longint'(mem[c][x / BIN_PX]);
        if (mmax[c] != 0 && cnt * V > longint'(row) * mmax[c]) begin
          e.pix[c*PIX_W +: PIX_W] = '1;
          any = 1'b1;
        end
      end
      if (x / BIN_PX == int'(thr)) e.red = '1;
`ifdef HISTO_DISP_GRID_EN
      if (!any && (row % (V / 4)) == 0) e.pix = {NUM_CH{8'h40}};
`endif
    end
    exp_q.push_back(e);
  endtask

  task automatic run_frame(input bit rnd, input int chg_y,
                           input logic [NUM_CH*CNT_W-1:0] chg_max, input int y_end);
    for (int y = 0; y < y_end; y++) begin
      int x;
      if (y == chg_y) mx = chg_max;
      x = 0;
      while (x < H) begin
        if (rnd && $urandom_range(0, 5) == 0)
          drive(1'b0, int'($urandom_range(0, H - 1)), int'($urandom_range(0, V - 1)));
        drive(1'b1, x, y);
        if (rnd && x > 0 && $urandom_range(0, 19) == 0) x += 2 + int'($urandom_range(0, 2));
        else x++;
      end
      drive(1'b0, 0, 0);
      drive(1'b0, 0, 0);
    end
    repeat (3) drive(1'b0, 0, 0);
  endtask

  function automatic logic [NUM_CH*CNT_W-1:0] all_max(input int val);
    logic [NUM_CH*CNT_W-1:0] m;
    m = '0;
    for (int c = 0; c < NUM_CH; c++) m[c*CNT_W +: CNT_W] = CNT_W'(val);
    return m;
  endfunction

  task automatic test_reset();
    @(negedge clk);
    total += 4;
    if (ov !== 1'b0)  begin bad++; $display("FAIL rst_valid got=%0b want=0", ov); end
    if (pix !== '0)   begin bad++; $display("FAIL rst_pixel got=%h want=0", pix); end
    if (red !== '0)   begin bad++; $display("FAIL rst_red got=%h want=0", red); end
    if (addr !== '0)  begin bad++; $display("FAIL rst_addr got=%0d want=0", addr); end
    foreach (mem[c, b]) mem[c][b] = CNT_W'($urandom_range(0, 100));
    mx = all_max(100);
    rst_n = 1'b1;
    model_reset();
    for (int x = 0; x < 12; x++) drive(1'b1, x, 0);
    for (int x = 0; x < 6; x++) drive(1'b1, x, 1);
    #2 rst_n = 1'b0;
    #1;
    total += 4;
    if (ov !== 1'b0)  begin bad++; $display("FAIL midrst_valid got=%0b want=0", ov); end
    if (pix !== '0)   begin bad++; $display("FAIL midrst_pixel got=%h want=0", pix); end
    if (red !== '0)   begin bad++; $display("FAIL midrst_red got=%h want=0", red); end
    if (addr !== '0)  begin bad++; $display("FAIL midrst_addr got=%0d want=0", addr); end
    vld = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    drive(1'b1, 0, 0);
    drive(1'b0, 7, 3);
    total++;
    if (ov !== 1'b0) begin bad++; $display("FAIL lat_cycle1 got=%0b want=0", ov); end
    drive(1'b0, 9, 2);
    total++;
    if (ov !== 1'b0) begin bad++; $display("FAIL lat_cycle2 got=%0b want=0", ov); end
    drive(1'b0, 4, 1);
    total++;
    if (ov !== 1'b1) begin bad++; $display("FAIL lat_cycle3 got=%0b want=1", ov); end
    repeat (3) drive(1'b0, 0, 0);
  endtask

  task automatic test_ramp();
    clear_tally();
    for (int b = 0; b < BINS; b++) begin
      mem[0][b] = CNT_W'(b * 4);
      mem[1][b] = CNT_W'($urandom_range(0, 1000));
      mem[2][b] = CNT_W'($urandom_range(0, 1000));
    end
    mx = all_max(int'($urandom_range(1, 1000)));
    mx[0 +: CNT_W] = CNT_W'(28);
    thr = 3'd7;
    run_frame(1'b0, -1, mx, V + 2);
    total += 4;
    if (lit_by_x[0][21] !== 16) begin bad++; $display("FAIL ramp_top_bin got=%0d want=16", lit_by_x[0][21]); end
    if (lit_by_x[0][0] !== 0)   begin bad++; $display("FAIL ramp_bin0 got=%0d want=0", lit_by_x[0][0]); end
    if (lit_by_x[0][3] !== 3)   begin bad++; $display("FAIL ramp_bin1 got=%0d want=3", lit_by_x[0][3]); end
    if (bg_hits !== 0)          begin bad++; $display("FAIL ramp_background got=%0d want=0", bg_hits); end
  endtask

  task automatic test_max_latch();
    foreach (mem[c, b]) mem[c][b] = CNT_W'(500);
    mx = all_max(1000);
    clear_tally();
    run_frame(1'b0, 8, all_max(2000), V);
    total += 2;
    if (lit_by_x[0][10] !== 8) begin bad++; $display("FAIL latch_frame1_ch0 got=%0d want=8", lit_by_x[0][10]); end
    if (lit_by_x[2][10] !== 8) begin bad++; $display("FAIL latch_frame1_ch2 got=%0d want=8", lit_by_x[2][10]); end
    clear_tally();
    run_frame(1'b0, -1, mx, V);
    total++;
    if (lit_by_x[0][10] !== 4) begin bad++; $display("FAIL latch_frame2_ch0 got=%0d want=4", lit_by_x[0][10]); end
  endtask

  task automatic test_edges();
    int s;
    for (int b = 0; b < BINS; b++) begin
      mem[0][b] = CNT_W'($urandom_range(1, 5000));
      mem[1][b] = '1;
      mem[2][b] = CNT_W'(101 + b);
    end
    mx = '0;
    mx[CNT_W +: CNT_W]   = '1;
    mx[2*CNT_W +: CNT_W] = CNT_W'(100);
    clear_tally();
    run_frame(1'b0, -1, mx, V);
    s = 0;
    for (int i = 0; i < H; i++) s += lit_by_x[0][i];
    total += 4;
    if (s !== 0)                begin bad++; $display("FAIL edge_max0 got=%0d want=0", s); end
    if (lit_by_x[1][0] !== 16)  begin bad++; $display("FAIL edge_fullscale_x0 got=%0d want=16", lit_by_x[1][0]); end
    if (lit_by_x[1][23] !== 16) begin bad++; $display("FAIL edge_fullscale_x23 got=%0d want=16", lit_by_x[1][23]); end
    if (lit_by_x[2][12] !== 16) begin bad++; $display("FAIL edge_clip got=%0d want=16", lit_by_x[2][12]); end
  endtask

  task automatic test_marker();
    int s;
    foreach (mem[c, b]) mem[c][b] = CNT_W'($urandom_range(0, 300));
    mx = all_max(300);
    thr = 3'd4;
    clear_tally();
    run_frame(1'b0, -1, mx, V + 2);
    s = 0;
    for (int i = 0; i < H; i++) s += red_by_x[i];
    total += 6;
    if (red_by_x[12] !== 16) begin bad++; $display("FAIL marker_x12 got=%0d want=16", red_by_x[12]); end
    if (red_by_x[14] !== 16) begin bad++; $display("FAIL marker_x14 got=%0d want=16", red_by_x[14]); end
    if (red_by_x[11] !== 0)  begin bad++; $display("FAIL marker_x11 got=%0d want=0", red_by_x[11]); end
    if (red_by_x[15] !== 0)  begin bad++; $display("FAIL marker_x15 got=%0d want=0", red_by_x[15]); end
    if (s !== 48)            begin bad++; $display("FAIL marker_total got=%0d want=48", s); end
    if (bg_hits !== 0)       begin bad++; $display("FAIL marker_background got=%0d want=0", bg_hits); end
  endtask

  task automatic test_grid();
    foreach (mem[c, b]) mem[c][b] = '0;
    mx = all_max(50);
    clear_tally();
    run_frame(1'b0, -1, mx, V);
    total += 3;
`ifdef HISTO_DISP_GRID_EN
    if (grid_by_y[15] !== PLOT) begin bad++; $display("FAIL grid_y15 got=%0d want=%0d", grid_by_y[15], PLOT); end
    if (grid_by_y[3] !== PLOT)  begin bad++; $display("FAIL grid_y3 got=%0d want=%0d", grid_by_y[3], PLOT); end
`else
    if (grid_by_y[15] !== 0)    begin bad++; $display("FAIL grid_y15 got=%0d want=0", grid_by_y[15]); end
    if (grid_by_y[3] !== 0)     begin bad++; $display("FAIL grid_y3 got=%0d want=0", grid_by_y[3]); end
`endif
    if (grid_by_y[14] !== 0)    begin bad++; $display("FAIL grid_y14 got=%0d want=0", grid_by_y[14]); end
  endtask

  task automatic test_random();
    for (int f = 0; f < 4; f++) begin
      foreach (mem[c, b])
        mem[c][b] = ($urandom_range(0, 7) == 0) ? CNT_W'($urandom) : CNT_W'($urandom_range(0, 2000));
      for (int c = 0; c < NUM_CH; c++)
        mx[c*CNT_W +: CNT_W] = ($urandom_range(0, 5) == 0) ? '0 : CNT_W'($urandom_range(1, 2000));
      thr = AW'($urandom_range(0, BINS - 1));
      run_frame(1'b1, int'($urandom_range(0, V - 1)), all_max(int'($urandom_range(1, 2000))),
                V + int'($urandom_range(0, 2)));
    end
  endtask

  initial begin
    clear_tally();
    foreach (mem[c, b]) mem[c][b] = '0;
    test_reset();
    test_ramp();
    test_max_latch();
    test_edges();
    test_marker();
    test_grid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
